// File: rtl/logic_gate_pkg.sv
// Shared gate opcodes and the bitwise gate function used by the logic_gate_pipe datapath.
// gate_fn works on a fixed maximum width; callers zero-extend and truncate to their own WIDTH (WIDTH <= GATE_MAX_W).
package logic_gate_pkg;

    localparam int OP_W       = 3;
    localparam int GATE_MAX_W = 64;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_NAND = 3'd1;
    localparam logic [OP_W-1:0] OP_OR   = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_W-1:0] OP_BUF  = 3'd7;

    function automatic logic [GATE_MAX_W-1:0] gate_fn(
        input logic [OP_W-1:0]       op,
        input logic [GATE_MAX_W-1:0] a,
        input logic [GATE_MAX_W-1:0] b
    );
        logic [GATE_MAX_W-1:0] y;
        case (op)
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_NOT:  y = ~a;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = a;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_gate_core.sv
// Combinational gate evaluation between the two pipeline stages: result plus zero/all-ones/parity flags.
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_zero,
    output logic             o_ones,
    output logic             o_par
);

    logic [GATE_MAX_W-1:0] w_a_ext;
    logic [GATE_MAX_W-1:0] w_b_ext;
    logic [GATE_MAX_W-1:0] w_y_full;
    logic                  w_unused_hi;

    always_comb begin
        w_a_ext = '0;
        w_b_ext = '0;
        w_a_ext[WIDTH-1:0] = i_a;
        w_b_ext[WIDTH-1:0] = i_b;
    end

    assign w_y_full    = gate_fn(i_op, w_a_ext, w_b_ext);
    // Bits above WIDTH (e.g. inverted zero-extension for NOT) are discarded.
    assign w_unused_hi = ^w_y_full;

    assign o_y    = w_y_full[WIDTH-1:0];
    assign o_zero = ~|o_y;
    assign o_ones = &o_y;
    assign o_par  = ^o_y;

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipeline applying a selectable bitwise gate to WIDTH-bit operands,
// with result flags and a modulo-2^CNT_W count of completed output handshakes.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_par,
    output logic [CNT_W-1:0] txn_count
);

    logic             r_vld_p1;
    logic [WIDTH-1:0] r_a_p1;
    logic [WIDTH-1:0] r_b_p1;
    logic [OP_W-1:0]  r_op_p1;

    logic             r_vld_p2;
    logic [WIDTH-1:0] r_y_p2;
    logic             r_zero_p2;
    logic             r_ones_p2;
    logic             r_par_p2;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_y;
    logic             w_zero;
    logic             w_ones;
    logic             w_par;

    assign w_s2_load  = r_vld_p1 && (!r_vld_p2 || out_ready);
    assign in_ready   = !r_vld_p1 || w_s2_load;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_vld_p2 && out_ready;

    // Stage 1: operand capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_a_p1   <= '0;
            r_b_p1   <= '0;
            r_op_p1  <= '0;
        end else if (w_in_fire) begin
            r_vld_p1 <= 1'b1;
            r_a_p1   <= in_a;
            r_b_p1   <= in_b;
            r_op_p1  <= in_op;
        end else if (w_s2_load) begin
            r_vld_p1 <= 1'b0;
        end
    end

    logic_gate_core #(.WIDTH(WIDTH)) u_core (
        .i_op   (r_op_p1),
        .i_a    (r_a_p1),
        .i_b    (r_b_p1),
        .o_y    (w_y),
        .o_zero (w_zero),
        .o_ones (w_ones),
        .o_par  (w_par)
    );

    // Stage 2: registered result and flags; holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_y_p2    <= '0;
            r_zero_p2 <= 1'b1;
            r_ones_p2 <= 1'b0;
            r_par_p2  <= 1'b0;
        end else if (w_s2_load) begin
            r_vld_p2  <= 1'b1;
            r_y_p2    <= w_y;
            r_zero_p2 <= w_zero;
            r_ones_p2 <= w_ones;
            r_par_p2  <= w_par;
        end else if (w_out_fire) begin
            r_vld_p2  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_out_fire) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_vld_p2;
    assign out_y     = r_y_p2;
    assign out_zero  = r_zero_p2;
    assign out_ones  = r_ones_p2;
    assign out_par   = r_par_p2;
    assign txn_count = r_cnt;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: per-cycle scoreboard against a queue model plus directed literal checks.
module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_zero;
    logic       out_ones;
    logic       out_par;
    logic [3:0] txn_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$];
    logic [7:0] obs[$];
    logic [3:0] m_cnt = 4'd0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_y = 8'd0;

    logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_par   (out_par),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return ~a;
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: outputs are stable mid-cycle; handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_cnt = 4'd0;
            prev_stall = 1'b0;
        end else begin
            chk("txn_count", {28'd0, txn_count}, {28'd0, m_cnt});
            if (prev_stall) chk("hold_y", {24'd0, out_y}, {24'd0, prev_y});
            if (q.size() == 0) begin
                chk("idle_valid", {31'd0, out_valid}, 32'd0);
            end else if (out_valid) begin
                chk("y",    {24'd0, out_y},    {24'd0, q[0]});
                chk("zero", {31'd0, out_zero}, {31'd0, (q[0] == 8'h00)});
                chk("ones", {31'd0, out_ones}, {31'd0, (q[0] == 8'hFF)});
                chk("par",  {31'd0, out_par},  {31'd0, ^q[0]});
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = out_y;
            if (out_valid && out_ready && q.size() != 0) begin
                obs.push_back(out_y);
                void'(q.pop_front());
                m_cnt = m_cnt + 4'd1;
            end
            if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b));
        end
    end

    task automatic wait_accept();
        logic acc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_op = op;
        in_a  = a;
        in_b  = b;
        wait_accept();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (out_valid) return;
            @(posedge clk);
            #1;
        end
        chk("valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) return;
        end
        chk("drain_timeout", {31'd0, 1'b1}, 32'd0);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_stream [8] = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'h0F, 8'hCC, 8'h33, 8'hF0};
    logic [7:0] held_y;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 8'd0;
        in_b = 8'd0;
        in_op = 3'd0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_txn",       {28'd0, txn_count}, 32'd0);
        chk("rst_zero",      {31'd0, out_zero},  32'd1);
        chk("rst_y",         {24'd0, out_y},     32'd0);
        chk("rst_ones",      {31'd0, out_ones},  32'd0);
        chk("rst_par",       {31'd0, out_par},   32'd0);

        // Stream all eight ops back to back
        out_ready = 1'b1;
        obs.delete();
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 8'hF0, 8'h3C);
            if (i == 0) chk("lat_after_accept", {31'd0, out_valid}, 32'd0);
            if (i == 1) chk("lat_next_edge",    {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        drain();
        chk("stream_count", {31'd0, 1'b0} + obs.size(), 32'd8);
        for (int i = 0; i < 8 && i < obs.size(); i++) chk($sformatf("stream_y%0d", i), {24'd0, obs[i]}, {24'd0, exp_stream[i]});
        chk("stream_txn", {28'd0, txn_count}, 32'd8);

        // Flag cases, held with out_ready low so they can be inspected
        out_ready = 1'b0;
        send(3'd0, 8'h00, 8'hFF);
        in_valid = 1'b0;
        wait_valid();
        chk("and_y", {24'd0, out_y}, 32'h00);
        chk("and_zero", {31'd0, out_zero}, 32'd1);
        chk("and_par", {31'd0, out_par}, 32'd0);
        pop_one();
        send(3'd6, 8'hAA, 8'hAA);
        in_valid = 1'b0;
        wait_valid();
        chk("xnor_y", {24'd0, out_y}, 32'hFF);
        chk("xnor_ones", {31'd0, out_ones}, 32'd1);
        chk("xnor_par", {31'd0, out_par}, 32'd0);
        pop_one();
        send(3'd7, 8'h01, 8'hFF);
        in_valid = 1'b0;
        wait_valid();
        chk("buf_y", {24'd0, out_y}, 32'h01);
        chk("buf_par", {31'd0, out_par}, 32'd1);
        pop_one();
        drain();

        // Back-pressure: three inputs against a stalled consumer
        obs.delete();
        send(3'd0, 8'hF0, 8'h3C);
        send(3'd5, 8'hF0, 8'h3C);
        in_valid = 1'b1;
        in_op = 3'd3;
        in_a = 8'h0F;
        in_b = 8'h10;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_y", {24'd0, out_y}, 32'h30);
        end
        held_y = out_y;
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        drain();
        chk("bp_count", {31'd0, 1'b0} + obs.size(), 32'd3);
        if (obs.size() == 3) begin
            chk("bp_y0", {24'd0, obs[0]}, {24'd0, held_y});
            chk("bp_y1", {24'd0, obs[1]}, 32'hCC);
            chk("bp_y2", {24'd0, obs[2]}, 32'hE0);
        end

        // Reset with two transactions in flight
        out_ready = 1'b0;
        send(3'd2, 8'h11, 8'h22);
        send(3'd1, 8'h11, 8'h22);
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_async_txn", {28'd0, txn_count}, 32'd0);
        chk("rst_async_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("no_stale_valid", {31'd0, out_valid}, 32'd0);
        end

        // Counter wrap with a 4-bit counter
        pulse_reset();
        for (int i = 0; i < 17; i++) send(3'd7, 8'(i), 8'h00);
        in_valid = 1'b0;
        drain();
        chk("wrap_txn", {28'd0, txn_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
